text_memory_fetch_bus: RTL and testbench
========================================

Name: text_memory_fetch_bus

Overview:
- Parametrised instruction-fetch bus between the core fetch stage and a synchronous text memory with fixed read latency.
- Replaces the combinational single-word text bus with:
  - a valid/ready request channel and a valid/ready response channel;
  - range and alignment fault reporting in place of X data;
  - configurable memory latency, plus an in-order response buffer that absorbs fetch-stage backpressure;
  - a flush input that discards pending fetches on redirect.

Parameters:
- TEXT_BEGIN, 32'h0040_0000, byte base of the text segment; must be aligned to 2**TEXT_BITS.
- TEXT_BITS, 16, log2 of text segment size in bytes; memory word address width is TEXT_BITS-2.
- MEM_LATENCY, 1, cycles from mem_read_enable to valid mem_q; legal range 1..4.
- RESP_DEPTH, 4, maximum responses in flight plus buffered; legal range 2..16.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  discard all pending and in-flight fetches
- req_valid  input  1  fetch request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_address  input  32  byte address of the fetch
- resp_valid  output  1  response at head of buffer
- resp_ready  input  1  fetch stage consumes the response
- resp_data  output  32  instruction word; 32'h0 on fault
- resp_fault  output  2  2'b00 ok, 2'b01 out of range, 2'b10 misaligned
- mem_read_enable  output  1  memory read strobe
- mem_address  output  TEXT_BITS-2  word address, equal to req_address[TEXT_BITS-1:2]
- mem_q  input  32  memory read data, valid MEM_LATENCY cycles after the strobe

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - clears the in-flight pipeline, the buffer and the counters;
  - req_ready=0, resp_valid=0, resp_data=0, resp_fault=0, mem_read_enable=0.
  - req_ready may rise in the first cycle after reset_n deasserts.
- Credit rule: req_ready = !flush && (inflight_count + buffer_count < RESP_DEPTH).
  - A response is therefore always guaranteed a buffer slot; the memory is never stalled.
- Classification of an accepted request, evaluated in the acceptance cycle T:
  - misaligned when req_address[1:0] != 0; this takes priority over range;
  - out of range when the address is outside TEXT_BEGIN .. TEXT_BEGIN+2**TEXT_BITS-1, inclusive both ends;
  - otherwise ok.
- Memory strobe: mem_read_enable=1 combinationally in cycle T only for an accepted ok request.
  - mem_address is always driven from req_address.
  - Faulted requests do not touch memory.
- Ordering:
  - Every accepted request, faulted or not, enters a MEM_LATENCY-stage tag shift register carrying a valid bit and a fault code.
  - At stage exit in cycle T+MEM_LATENCY, the entry is written to the FIFO with data = mem_q if ok, else 32'h0.
  - Responses stay strictly in request order.
- Latency: for an accepted request in cycle T with an empty buffer, resp_valid=1 in cycle T+MEM_LATENCY+1.
  - resp_data and resp_fault are registered FIFO-head outputs.
- Throughput: one request per cycle sustained while resp_ready=1.
- Pop: the head is removed on resp_valid && resp_ready; the next entry appears the following cycle.
  - resp_data and resp_fault hold stable while resp_valid && !resp_ready.
- Simultaneous push and pop on a full buffer is legal; the count is unchanged.
- Flush:
  - Takes effect at the clock edge; invalidates all tag stages and empties the FIFO.
  - resp_valid=0 the next cycle.
  - A request presented during flush is not accepted, because req_ready=0.
  - mem_q returning for flushed reads is ignored.
  - Flush has priority over a simultaneous pop.
- Counters:
  - inflight_count = number of valid tag stages.
  - buffer_count has width $clog2(RESP_DEPTH+1).
  - Neither counter may overflow or underflow; assertions are required in simulation.
- FIFO pointers wrap modulo RESP_DEPTH; a non-power-of-two depth must work.
- Address compare: unsigned 32-bit; TEXT_BEGIN+2**TEXT_BITS-1 must not overflow 32 bits (elaboration check).

Test Plan:
1. Reset and single fetch: release reset; req 32'h0040_0000 (MEM_LATENCY=1) -> mem_read_enable=1 with mem_address=0 in cycle T; resp_valid in T+2 with resp_data=mem_q and resp_fault=00.
2. Boundaries: req 32'h0040_FFFC -> ok, mem_address=14'h3FFF; req 32'h0041_0000 -> fault 01, data 0, no mem_read_enable; req 32'h0040_0002 -> fault 10.
3. Mixed order: back-to-back ok, out-of-range, ok requests -> three responses in the same order with fault codes 00, 01, 00; data matches the memory model.
4. Backpressure: resp_ready=0 while issuing requests (RESP_DEPTH=4) -> exactly 4 accepted, req_ready=0 afterwards; raise resp_ready -> 4 in-order responses, then req_ready=1 again.
5. Flush: 3 requests in flight with MEM_LATENCY=3, assert flush for 1 cycle -> resp_valid stays 0 and late mem_q is discarded; a subsequent request returns only its own data.
6. Async reset mid-stream: drop reset_n between clock edges with a full buffer -> resp_valid and req_ready go to 0 immediately; after release, a fresh fetch completes normally.

Source files
------------

// File: rtl/text_memory_fetch_bus.sv
// ---------------------------------------------------------------------------
// text_memory_fetch_bus
//
// Instruction-fetch bus between the core fetch stage and a synchronous text
// memory with a fixed read latency. Requests are classified (ok, out of
// range, misaligned) in the cycle they are accepted. Only ok requests strobe
// the memory. Every accepted request carries a tag through a MEM_LATENCY-deep
// shift register so that faulted and ok responses leave in request order. An
// in-order response FIFO absorbs fetch-stage backpressure.
//
// Handshakes: both channels transfer on a rising clock edge where valid and
// ready are both high. resp_valid never depends on resp_ready. Once
// resp_valid is high, resp_data and resp_fault hold until the pop.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   flush                 discard every pending and in-flight fetch
//   req_valid/req_ready   request channel, req_address = byte address
//   resp_valid/resp_ready response channel, resp_data / resp_fault
//   mem_read_enable       memory read strobe, mem_address = word address
//   mem_q                 memory read data, valid MEM_LATENCY cycles later
// ---------------------------------------------------------------------------
module text_memory_fetch_bus #(
    parameter logic [31:0] TEXT_BEGIN  = 32'h0040_0000,
    parameter int          TEXT_BITS   = 16,
    parameter int          MEM_LATENCY = 1,
    parameter int          RESP_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_address,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_data,
    output logic [1:0]           resp_fault,
    output logic                 mem_read_enable,
    output logic [TEXT_BITS-3:0] mem_address,
    input  logic [31:0]          mem_q
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam logic [63:0] TEXT_END_64 = {32'h0, TEXT_BEGIN} + (64'd1 << TEXT_BITS) - 64'd1;
    localparam logic [63:0] SEG_MASK_64 = (64'd1 << TEXT_BITS) - 64'd1;
    localparam logic [31:0] TEXT_END    = TEXT_END_64[31:0];

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_RANGE = 2'b01;
    localparam logic [1:0] F_ALIGN = 2'b10;

    // Elaboration-time parameter checks.
    generate
        if (TEXT_END_64 > 64'h0000_0000_FFFF_FFFF) begin : g_bad_end
            $error("text segment end overflows 32 bits");
        end
        if (({32'h0, TEXT_BEGIN} & SEG_MASK_64) != 64'd0) begin : g_bad_align
            $error("TEXT_BEGIN is not aligned to the segment size");
        end
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
            $error("MEM_LATENCY must be in 1..4");
        end
        if (RESP_DEPTH < 2 || RESP_DEPTH > 16) begin : g_bad_depth
            $error("RESP_DEPTH must be in 2..16");
        end
    endgenerate

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic                   r_run;
    logic [MEM_LATENCY-1:0] r_tag_v;
    logic [1:0]             r_tag_f [MEM_LATENCY];
    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          r_buf_count;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [31:0]            r_buf_data  [RESP_DEPTH];
    logic [1:0]             r_buf_fault [RESP_DEPTH];
    logic                   r_resp_valid;
    logic [31:0]            r_resp_data;
    logic [1:0]             r_resp_fault;

    logic [1:0]    w_fault;
    logic [CW:0]   w_total;
    logic          w_accept;
    logic          w_exit_valid;
    logic [1:0]    w_exit_fault;
    logic [31:0]   w_exit_data;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_head_data;
    logic [1:0]    w_head_fault;

    // Misalignment outranks the range check.
    assign w_fault = (req_address[1:0] != 2'b00) ? F_ALIGN :
                     ((req_address < TEXT_BEGIN) || (req_address > TEXT_END)) ? F_RANGE : F_OK;

    // Credit rule: every accepted request already owns a FIFO slot, so the
    // memory pipeline never has to stall.
    assign w_total   = {1'b0, r_inflight} + {1'b0, r_buf_count};
    assign req_ready = r_run && !flush && (w_total < (CW + 1)'(RESP_DEPTH));
    assign w_accept  = req_valid && req_ready;

    assign mem_read_enable = w_accept && (w_fault == F_OK);
    assign mem_address     = req_address[TEXT_BITS-1:2];

    assign w_exit_valid = r_tag_v[MEM_LATENCY-1];
    assign w_exit_fault = r_tag_f[MEM_LATENCY-1];
    assign w_exit_data  = (w_exit_fault == F_OK) ? mem_q : 32'h0;
    assign w_push       = w_exit_valid;
    assign w_pop        = r_resp_valid && resp_ready;

    // Next value of the registered head outputs. The FIFO holds the head as
    // well; the output registers mirror storage[rd_ptr].
    always_comb begin
        w_count_next = r_buf_count;
        if (w_push && !w_pop) begin
            w_count_next = r_buf_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_buf_count - CW'(1);
        end
        w_head_data  = 32'h0;
        w_head_fault = F_OK;
        if (w_count_next != '0) begin
            if ((r_buf_count == '0) || ((r_buf_count == CW'(1)) && w_pop)) begin
                // The entry being pushed becomes the head directly.
                w_head_data  = w_exit_data;
                w_head_fault = w_exit_fault;
            end else if (w_pop) begin
                w_head_data  = r_buf_data[ptr_inc(r_rd_ptr)];
                w_head_fault = r_buf_fault[ptr_inc(r_rd_ptr)];
            end else begin
                w_head_data  = r_resp_data;
                w_head_fault = r_resp_fault;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run        <= 1'b0;
            r_tag_v      <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_tag_f[i] <= F_OK;
            end
            r_inflight   <= '0;
            r_buf_count  <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_buf_data[i]  <= 32'h0;
                r_buf_fault[i] <= F_OK;
            end
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_fault <= F_OK;
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                // Flush beats push and pop; late mem_q is dropped because no
                // tag stage is left valid to claim it.
                r_tag_v      <= '0;
                r_inflight   <= '0;
                r_buf_count  <= '0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_resp_valid <= 1'b0;
                r_resp_data  <= 32'h0;
                r_resp_fault <= F_OK;
            end else begin
                r_tag_v[0] <= w_accept;
                r_tag_f[0] <= w_fault;
                for (int i = 1; i < MEM_LATENCY; i++) begin
                    r_tag_v[i] <= r_tag_v[i-1];
                    r_tag_f[i] <= r_tag_f[i-1];
                end
                r_inflight <= r_inflight + CW'(w_accept) - CW'(w_exit_valid);
                if (w_push) begin
                    r_buf_data[r_wr_ptr]  <= w_exit_data;
                    r_buf_fault[r_wr_ptr] <= w_exit_fault;
                    r_wr_ptr              <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                r_buf_count  <= w_count_next;
                r_resp_valid <= (w_count_next != '0);
                r_resp_data  <= w_head_data;
                r_resp_fault <= w_head_fault;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_fault = r_resp_fault;

`ifndef SYNTHESIS
    a_buf_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(!flush && w_push && !w_pop && (r_buf_count == CW'(RESP_DEPTH))));
    a_buf_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(!flush && w_pop && (r_buf_count == '0)));
    a_inflight_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(!flush && w_accept && !w_exit_valid && (r_inflight == CW'(MEM_LATENCY))));
    a_inflight_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(!flush && w_exit_valid && !w_accept && (r_inflight == '0)));
`endif

endmodule

// File: tb/tb_text_memory_fetch_bus.sv
module tb_text_memory_fetch_bus;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    int          errors = 0;
    int          checks = 0;

    // Instance with MEM_LATENCY=1
    logic        flush, req_valid, req_ready, resp_valid, resp_ready, mem_read_enable;
    logic [31:0] req_address, resp_data, mem_q;
    logic [1:0]  resp_fault;
    logic [13:0] mem_address;

    // Instance with MEM_LATENCY=3
    logic        b_flush, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_mem_read_enable;
    logic [31:0] b_req_address, b_resp_data, b_mem_q;
    logic [1:0]  b_resp_fault;
    logic [13:0] b_mem_address;

    text_memory_fetch_bus #(.MEM_LATENCY(1), .RESP_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_fault(resp_fault), .mem_read_enable(mem_read_enable),
        .mem_address(mem_address), .mem_q(mem_q)
    );

    text_memory_fetch_bus #(.MEM_LATENCY(3), .RESP_DEPTH(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_address(b_req_address),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .resp_fault(b_resp_fault), .mem_read_enable(b_mem_read_enable),
        .mem_address(b_mem_address), .mem_q(b_mem_q)
    );

    // Synchronous text memory models: word w reads as base | w.
    logic [14:0] a_pipe;
    logic [14:0] b_pipe [3];
    always @(posedge clock) begin
        a_pipe    <= {mem_read_enable, mem_address};
        b_pipe[0] <= {b_mem_read_enable, b_mem_address};
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign mem_q   = a_pipe[14]    ? (32'hC0DE_0000 | {18'h0, a_pipe[13:0]})    : 32'hBAD0_BAD0;
    assign b_mem_q = b_pipe[2][14] ? (32'hB000_0000 | {18'h0, b_pipe[2][13:0]}) : 32'hBAD1_BAD1;

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_address = 32'h0040_0000; resp_ready = 1'b0;
        b_flush = 1'b0; b_req_valid = 1'b0; b_req_address = 32'h0; b_resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b expected 0", mem_read_enable); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        checks++; if (resp_fault !== 2'b00) begin errors++; $display("FAIL reset_resp_fault: got %b expected 00", resp_fault); end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_single_fetch();
        req_valid = 1'b1; req_address = 32'h0040_0000; resp_ready = 1'b0;
        #1;
        checks++; if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL single_mem_re: got %b expected 1", mem_read_enable); end
        checks++; if (mem_address !== 14'h0) begin errors++; $display("FAIL single_mem_addr: got %h expected 0000", mem_address); end
        @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", resp_valid); end
        @(negedge clock);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_data !== 32'hC0DE_0000) begin errors++; $display("FAIL single_resp_data: got %h expected c0de0000", resp_data); end
        checks++; if (resp_fault !== 2'b00) begin errors++; $display("FAIL single_resp_fault: got %b expected 00", resp_fault); end
        resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b expected 0", resp_valid); end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [4];
        logic        exp_re [4];
        logic [13:0] exp_ma [4];
        logic [31:0] exp_d  [4];
        logic [1:0]  exp_f  [4];
        addrs  = '{32'h0040_FFFC, 32'h0041_0000, 32'h0040_0002, 32'h003F_FFFC};
        exp_re = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_ma = '{14'h3FFF, 14'h0000, 14'h0000, 14'h3FFF};
        exp_d  = '{32'hC0DE_3FFF, 32'h0, 32'h0, 32'h0};
        exp_f  = '{2'b00, 2'b01, 2'b10, 2'b01};
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_address = addrs[i];
            #1;
            checks++; if (mem_read_enable !== exp_re[i]) begin errors++; $display("FAIL bound%0d_mem_re: got %b expected %b", i, mem_read_enable, exp_re[i]); end
            checks++; if (mem_address !== exp_ma[i]) begin errors++; $display("FAIL bound%0d_mem_addr: got %h expected %h", i, mem_address, exp_ma[i]); end
            @(negedge clock);
            req_valid = 1'b0;
            @(negedge clock);
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bound%0d_valid: got %b expected 1", i, resp_valid); end
            checks++; if (resp_data !== exp_d[i]) begin errors++; $display("FAIL bound%0d_data: got %h expected %h", i, resp_data, exp_d[i]); end
            checks++; if (resp_fault !== exp_f[i]) begin errors++; $display("FAIL bound%0d_fault: got %b expected %b", i, resp_fault, exp_f[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp_d [3];
        logic [1:0]  exp_f [3];
        int n;
        addrs = '{32'h0040_0010, 32'h0050_0000, 32'h0040_0020};
        exp_d = '{32'hC0DE_0004, 32'h0, 32'hC0DE_0008};
        exp_f = '{2'b00, 2'b01, 2'b00};
        n = 0;
        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (resp_valid) begin
                checks++;
                if (n >= 3) begin
                    errors++; $display("FAIL b2b_extra_resp: got data %h expected no response", resp_data);
                end else if (resp_data !== exp_d[n] || resp_fault !== exp_f[n]) begin
                    errors++; $display("FAIL b2b_resp%0d: got %h/%b expected %h/%b", n, resp_data, resp_fault, exp_d[n], exp_f[n]);
                end
                n++;
            end
            if (cyc < 3) begin
                req_valid = 1'b1; req_address = addrs[cyc];
                #1;
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", cyc, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n); end
    endtask

    task automatic test_backpressure();
        int accepted;
        int n;
        accepted = 0;
        resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_address = 32'h0040_0100 + 32'(4 * i);
            #1;
            if (req_ready) accepted++;
            @(negedge clock);
        end
        checks++; if (accepted != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", accepted); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", req_ready); end
        req_valid = 1'b0;
        checks++; if (resp_data !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_head: got %h expected c0de0040", resp_data); end
        @(negedge clock);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_hold: got %b/%h expected 1/c0de0040", resp_valid, resp_data); end
        resp_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (resp_valid) begin
                checks++;
                if (resp_data !== (32'hC0DE_0040 + 32'(n)) || resp_fault !== 2'b00) begin
                    errors++; $display("FAIL bp_resp%0d: got %h/%b expected %h/00", n, resp_data, resp_fault, 32'hC0DE_0040 + 32'(n));
                end
                n++;
            end
            @(negedge clock);
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_flush();
        int seen;
        int lat;
        b_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_req_valid = 1'b1; b_req_address = 32'h0040_0000 + 32'(4 * i);
            #1;
            checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL flush_issue%0d: got %b expected 1", i, b_req_ready); end
            @(negedge clock);
        end
        b_flush = 1'b1; b_req_address = 32'h0040_0040;
        #1;
        checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", b_req_ready); end
        checks++; if (b_mem_read_enable !== 1'b0) begin errors++; $display("FAIL flush_mem_re: got %b expected 0", b_mem_read_enable); end
        @(negedge clock);
        b_flush = 1'b0; b_req_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (b_resp_valid) seen++;
            @(negedge clock);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak: got %0d responses expected 0", seen); end
        b_req_valid = 1'b1; b_req_address = 32'h0040_0080;
        @(negedge clock);
        b_req_valid = 1'b0;
        lat = 1;
        while (!b_resp_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL flush_latency: got %0d expected 4", lat); end
        checks++; if (b_resp_data !== 32'hB000_0020 || b_resp_fault !== 2'b00) begin errors++; $display("FAIL flush_after_data: got %h/%b expected b0000020/00", b_resp_data, b_resp_fault); end
        @(negedge clock);
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (b_resp_valid) seen++;
            @(negedge clock);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_after_extra: got %0d responses expected 0", seen); end
    endtask

    task automatic test_async_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_address = 32'h0040_0200 + 32'(4 * i);
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL areset_full: got valid %b ready %b expected 1 0", resp_valid, req_ready); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b expected 0", req_ready); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", resp_data); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_address = 32'h0040_0008;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_read_enable !== 1'b1) begin errors++; $display("FAIL areset_refetch_req: got ready %b re %b expected 1 1", req_ready, mem_read_enable); end
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hC0DE_0002 || resp_fault !== 2'b00) begin
            errors++; $display("FAIL areset_refetch_resp: got %b/%h/%b expected 1/c0de0002/00", resp_valid, resp_data, resp_fault);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
